// File: rtl/exec_vect_pkg.sv
// Shared types for the SIMD vector execute stage: ALU opcodes, B-operand select codes, default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_vect_pkg;

   // Default lane geometry.
   localparam int EV_N     = 24;
   localparam int EV_LANES = 2;

   // Per-lane ALU operation. The encodings are the instruction-decoder contract, so they are
   // listed explicitly rather than left to enum auto-numbering.
   typedef enum logic [3:0] {
      OP_MOV   = 4'b0000,   // B
      OP_SUB   = 4'b0001,   // A - B
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLL   = 4'b0101,   // A << B[4:0]
      OP_SRL   = 4'b0110,   // A >> B[4:0]
      OP_SRA   = 4'b0111,   // signed A >>> B[4:0]
      OP_MUL   = 4'b1000,   // low N bits of A * B (zero when the multiplier is not built)
      OP_MIN   = 4'b1001,   // unsigned
      OP_MAX   = 4'b1010,   // unsigned
      OP_NOT   = 4'b1011,   // ~A
      OP_PASSA = 4'b1100,   // A
      OP_ADD   = 4'b1101,   // A + B
      OP_SLT   = 4'b1110,   // signed A < B
      OP_ZERO  = 4'b1111
   } alu_op_e;

   // B-operand select, indexed by {Fb, immSrc}.
   localparam logic [1:0] BSEL_RD2  = 2'b00;
   localparam logic [1:0] BSEL_IMM  = 2'b01;
   localparam logic [1:0] BSEL_FWD  = 2'b10;
   localparam logic [1:0] BSEL_ZERO = 2'b11;

endpackage

// File: rtl/exec_vect_lane_alu.sv
// One N-bit lane of the vector ALU; all arithmetic wraps mod 2^N.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
//
// Ports: op (alu_op_e), a / b (N-bit operands), y (N-bit result).
// Build option EXEC_VECT_MUL_EN: when defined, OP_MUL uses an N x N multiplier (low N bits);
// otherwise no multiplier exists and OP_MUL yields 0.
module exec_vect_lane_alu
   import exec_vect_pkg::*;
#(
   parameter int N = EV_N
) (
   input  alu_op_e      op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   logic [4:0]   shamt;
   logic         sh_oor;    // shift amount reaches or exceeds the lane width
   logic [N-1:0] mul_lo;

   assign shamt  = b[4:0];
   assign sh_oor = (int'(shamt) >= N);

`ifdef EXEC_VECT_MUL_EN
   assign mul_lo = a * b;
`else
   assign mul_lo = '0;
`endif

   always_comb begin
      y = '0;
      case (op)
         OP_MOV:   y = b;
         OP_SUB:   y = a - b;
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_SLL:   y = sh_oor ? '0 : (a << shamt);
         OP_SRL:   y = sh_oor ? '0 : (a >> shamt);
         OP_SRA:   y = sh_oor ? {N{a[N-1]}} : $unsigned($signed(a) >>> shamt);
         OP_MUL:   y = mul_lo;
         OP_MIN:   y = (a < b) ? a : b;
         OP_MAX:   y = (a > b) ? a : b;
         OP_NOT:   y = ~a;
         OP_PASSA: y = a;
         OP_ADD:   y = a + b;
         OP_SLT:   y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_ZERO:  y = '0;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/exec_vect.sv
// Vector execute stage: per-lane operand muxing, LANES lane ALUs, and store-data pass-through.
// Latency: 1 cycle from ID/EX inputs to registered EX/MEM outputs.
// Backpressure: none; there is no stall or enable, so the stage captures every cycle.
//
// Ports: clk, rst_n (async active-low); rd1/rd2/rd3 register sources; Forward1/2/3 bypass values;
// imm scalar broadcast to all lanes; aluControl opcode; immSrc/Fb pick B, Fa picks A, Fc picks C;
// aluCurrentResult and RD3Out are the registered results. Lane i occupies bits [i*N +: N].
// Build option EXEC_VECT_MUL_EN enables the per-lane multiplier (see exec_vect_lane_alu).
module exec_vect
   import exec_vect_pkg::*;
#(
   parameter int N     = EV_N,
   parameter int LANES = EV_LANES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LANES*N-1:0] rd1,
   input  logic [LANES*N-1:0] rd2,
   input  logic [LANES*N-1:0] rd3,
   input  logic [LANES*N-1:0] Forward1,
   input  logic [LANES*N-1:0] Forward2,
   input  logic [LANES*N-1:0] Forward3,
   input  logic [N-1:0]       imm,
   input  logic [3:0]         aluControl,
   input  logic               immSrc,
   input  logic               Fa,
   input  logic               Fb,
   input  logic               Fc,
   output logic [LANES*N-1:0] aluCurrentResult,
   output logic [LANES*N-1:0] RD3Out
);

   logic [LANES*N-1:0] alu_vec;
   logic [LANES*N-1:0] c_vec;
   alu_op_e            op;

   assign op = alu_op_e'(aluControl);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [N-1:0] a_l;
      logic [N-1:0] b_l;

      always_comb begin
         a_l = Fa ? Forward1[i*N +: N] : rd1[i*N +: N];
         b_l = '0;
         case ({Fb, immSrc})
            BSEL_RD2:  b_l = rd2[i*N +: N];
            BSEL_IMM:  b_l = imm;
            BSEL_FWD:  b_l = Forward2[i*N +: N];
            BSEL_ZERO: b_l = '0;
            default:   b_l = '0;
         endcase
      end

      assign c_vec[i*N +: N] = Fc ? Forward3[i*N +: N] : rd3[i*N +: N];

      exec_vect_lane_alu #(.N(N)) u_alu (
         .op (op),
         .a  (a_l),
         .b  (b_l),
         .y  (alu_vec[i*N +: N])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluCurrentResult <= '0;
         RD3Out           <= '0;
      end else begin
         aluCurrentResult <= alu_vec;
         RD3Out           <= c_vec;
      end
   end

endmodule

// File: tb/tb_exec_vect.sv
// Directed bench for exec_vect with hand-computed expectations (N=24, LANES=2).
// Inputs change on negedge, results are checked on the following negedge.
// Build option EXEC_VECT_MUL_EN selects the multiply expectation.
module tb_exec_vect;

   localparam int N     = 24;
   localparam int LANES = 2;
   localparam int W     = N * LANES;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   rd1, rd2, rd3, Forward1, Forward2, Forward3;
   logic [N-1:0]   imm;
   logic [3:0]     aluControl;
   logic           immSrc, Fa, Fb, Fc;
   logic [W-1:0]   aluCurrentResult, RD3Out;

   int n_checks = 0;
   int n_errors = 0;

   exec_vect #(.N(N), .LANES(LANES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rd1              (rd1),
      .rd2              (rd2),
      .rd3              (rd3),
      .Forward1         (Forward1),
      .Forward2         (Forward2),
      .Forward3         (Forward3),
      .imm              (imm),
      .aluControl       (aluControl),
      .immSrc           (immSrc),
      .Fa               (Fa),
      .Fb               (Fb),
      .Fc               (Fc),
      .aluCurrentResult (aluCurrentResult),
      .RD3Out           (RD3Out)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] v(input logic [N-1:0] l1, input logic [N-1:0] l0);
      return {l1, l0};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply opcode at the current negedge, check the registered ALU result one cycle later.
   task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] exp);
      aluControl = op;
      @(negedge clk);
      check(tag, aluCurrentResult, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd1 = '0; rd2 = '0; rd3 = '0;
      Forward1 = '0; Forward2 = '0; Forward3 = '0;
      imm = '0; aluControl = 4'b0000;
      immSrc = 1'b0; Fa = 1'b0; Fb = 1'b0; Fc = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_alu", aluCurrentResult, '0);
      check("reset_rd3", RD3Out, '0);
      @(negedge clk);
      check("reset_hold_alu", aluCurrentResult, '0);
      rst_n = 1'b1;

      // Basic add, operand muxes, store-data select.
      rd1 = v(24'd2, 24'd1); rd2 = v(24'd4, 24'd3);
      rd3 = v(24'd12, 24'd11); Forward3 = v(24'd10, 24'd9);
      Forward1 = v(24'd6, 24'd5); Forward2 = v(24'd8, 24'd7);
      run("add_rd", 4'b1101, v(24'd6, 24'd4));
      check("rd3_sel", RD3Out, v(24'd12, 24'd11));

      Fa = 1'b1; Fc = 1'b1;
      run("add_fwdA", 4'b1101, v(24'd10, 24'd8));
      check("fwd3_sel", RD3Out, v(24'd10, 24'd9));

      Fb = 1'b1;
      run("add_fwdAB", 4'b1101, v(24'd14, 24'd12));

      Fa = 1'b0; Fb = 1'b0; immSrc = 1'b1; imm = 24'd5;
      run("add_imm", 4'b1101, v(24'd7, 24'd6));

      Fb = 1'b1;
      run("add_zeroB", 4'b1101, v(24'd2, 24'd1));

      Fb = 1'b0; immSrc = 1'b0;
      run("mov_b", 4'b0000, v(24'd4, 24'd3));
      run("pass_a", 4'b1100, v(24'd2, 24'd1));

      // Lane isolation: no carry/borrow crosses the lane boundary.
      rd1 = v(24'd0, 24'hFFFFFF); rd2 = v(24'd0, 24'd1);
      run("add_wrap", 4'b1101, v(24'd0, 24'd0));
      rd1 = v(24'd5, 24'd0); rd2 = v(24'd0, 24'd1);
      run("sub_wrap", 4'b0001, v(24'd5, 24'hFFFFFF));

      // Logic ops.
      rd1 = v(24'hFF00FF, 24'h0000F0); rd2 = v(24'h0F0F0F, 24'h0000FF);
      run("and", 4'b0010, v(24'h0F000F, 24'h0000F0));
      run("or",  4'b0011, v(24'hFF0FFF, 24'h0000FF));
      run("xor", 4'b0100, v(24'hF00FF0, 24'h00000F));
      rd1 = v(24'h000000, 24'h0F0F0F);
      run("not", 4'b1011, v(24'hFFFFFF, 24'hF0F0F0));

      // Shifts, including amount == N and upper B bits ignored.
      rd1 = v(24'h800000, 24'h000010); rd2 = v(24'd24, 24'd4);
      run("sll", 4'b0101, v(24'h000000, 24'h000100));
      run("srl", 4'b0110, v(24'h000000, 24'h000001));
      run("sra_oor", 4'b0111, v(24'hFFFFFF, 24'h000001));
      rd2 = v(24'h000023, 24'd4);
      run("sra_b5", 4'b0111, v(24'hF00000, 24'h000001));

      // Signed compare versus unsigned min/max.
      rd1 = v(24'hFFFFFF, 24'd1); rd2 = v(24'd1, 24'hFFFFFF);
      run("slt", 4'b1110, v(24'd1, 24'd0));
      run("min", 4'b1001, v(24'd1, 24'd1));
      run("max", 4'b1010, v(24'hFFFFFF, 24'hFFFFFF));
      run("zero_op", 4'b1111, v(24'd0, 24'd0));

      // Multiply.
      rd1 = v(24'd3, 24'd2); rd2 = v(24'd3, 24'd2);
`ifdef EXEC_VECT_MUL_EN
      run("mul", 4'b1000, v(24'd9, 24'd4));
`else
      run("mul_off", 4'b1000, v(24'd0, 24'd0));
`endif

      // Asynchronous reset mid-cycle after nonzero outputs.
      run("pre_reset", 4'b1101, v(24'd6, 24'd4));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_alu", aluCurrentResult, '0);
      check("async_rst_rd3", RD3Out, '0);
      @(negedge clk);
      check("rst_hold_rd3", RD3Out, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_alu", aluCurrentResult, v(24'd6, 24'd4));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
